// File: rtl/sp_writeback_arbiter.sv
// Writeback arbiter: merges the non-stalling ALU path and FIFO-buffered load returns
// onto the single register-file write port, and tracks which registers have loads outstanding.
module sp_writeback_arbiter #(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_R0    = 1
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     alu_valid,
  input  logic [REG_AW-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     ld_issue,
  input  logic [REG_AW-1:0]        ld_issue_rd,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [REG_AW-1:0]        mem_rd,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     RegWE,
  output logic [REG_AW-1:0]        nD,
  output logic [DATA_W-1:0]        D,
  output logic [(1<<REG_AW)-1:0]   pending,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << REG_AW;

  logic [REG_AW-1:0] fifo_rd_q   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              regwe_q, regwe_d, wb_load_q, wb_load_d;
  logic [REG_AW-1:0] nd_q, nd_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              push, pop;

  // Full FIFO refuses returns even while popping: no pop-through path.
  assign mem_ready = (count_q < CW'(FIFO_DEPTH));
  assign push      = mem_valid && mem_ready;
  assign pop       = !alu_valid && (count_q != '0);
  assign count_d   = count_q + CW'(push) - CW'(pop);

  always_comb begin
    regwe_d   = 1'b0;
    wb_load_d = 1'b0;
    nd_d      = nd_q;
    d_d       = d_q;
    if (alu_valid) begin
      nd_d    = alu_rd;
      d_d     = alu_data;
      regwe_d = !((DROP_R0 != 0) && (alu_rd == '0));
    end else if (pop) begin
      nd_d      = fifo_rd_q[rd_ptr_q];
      d_d       = fifo_data_q[rd_ptr_q];
      regwe_d   = !((DROP_R0 != 0) && (fifo_rd_q[rd_ptr_q] == '0));
      wb_load_d = 1'b1;
    end
  end

  // Clear applied first so a same-edge issue to the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (regwe_q && wb_load_q)
      pending_d[nd_q] = 1'b0;
    if (ld_issue && !((DROP_R0 != 0) && (ld_issue_rd == '0)))
      pending_d[ld_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= mem_rd;
      fifo_data_q[wr_ptr_q] <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      regwe_q   <= 1'b0;
      wb_load_q <= 1'b0;
      nd_q      <= '0;
      d_q       <= '0;
      pending_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q   <= count_d;
      regwe_q   <= regwe_d;
      wb_load_q <= wb_load_d;
      nd_q      <= nd_d;
      d_q       <= d_d;
      pending_q <= pending_d;
    end
  end

  assign RegWE      = regwe_q;
  assign nD         = nd_q;
  assign D          = d_q;
  assign pending    = pending_q;
  assign fifo_count = count_q;
endmodule

// File: tb/tb_sp_writeback_arbiter.sv
// Directed bench for sp_writeback_arbiter: ALU path, load round trip, contention,
// R0 suppression, same-edge pending set/clear and mid-stream reset.
module tb_sp_writeback_arbiter;
  logic        clk = 1'b0;
  logic        Reset;
  logic        alu_valid;
  logic [3:0]  alu_rd;
  logic [15:0] alu_data;
  logic        ld_issue;
  logic [3:0]  ld_issue_rd;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_rd;
  logic [15:0] mem_data;
  logic        RegWE;
  logic [3:0]  nD;
  logic [15:0] D;
  logic [15:0] pending;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fails  = 0;

  sp_writeback_arbiter #(.DATA_W(16), .REG_AW(4), .FIFO_DEPTH(4), .DROP_R0(1)) dut (
    .clk(clk), .Reset(Reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .RegWE(RegWE), .nD(nD), .D(D), .pending(pending), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int k;
    logic acc;
    Reset = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_issue_rd = 0; mem_valid = 0; mem_rd = 0; mem_data = 0;
    tick(); tick();
    Reset = 1'b0;
    tick();
    chk("rst_regwe", 32'(RegWE), 0);
    chk("rst_nd", 32'(nD), 0);
    chk("rst_d", 32'(D), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ready", 32'(mem_ready), 1);

    // ALU only
    alu_valid = 1; alu_rd = 5; alu_data = 16'h1234;
    tick();
    chk("alu_regwe", 32'(RegWE), 1);
    chk("alu_nd", 32'(nD), 5);
    chk("alu_d", 32'(D), 32'h1234);
    alu_valid = 0;
    tick();
    chk("alu_idle_regwe", 32'(RegWE), 0);
    chk("alu_idle_nd_hold", 32'(nD), 5);

    // Load round trip
    ld_issue = 1; ld_issue_rd = 3;
    tick();
    ld_issue = 0;
    chk("ld_pend_set", 32'(pending), 32'h0008);
    mem_valid = 1; mem_rd = 3; mem_data = 16'hBEEF;
    tick();
    mem_valid = 0;
    chk("ld_count1", 32'(fifo_count), 1);
    chk("ld_regwe_early", 32'(RegWE), 0);
    tick();
    chk("ld_regwe", 32'(RegWE), 1);
    chk("ld_nd", 32'(nD), 3);
    chk("ld_d", 32'(D), 32'hBEEF);
    chk("ld_pend_still", 32'(pending), 32'h0008);
    chk("ld_count0", 32'(fifo_count), 0);
    tick();
    chk("ld_pend_clr", 32'(pending), 0);
    chk("ld_regwe_off", 32'(RegWE), 0);

    // Contention: ALU busy 6 cycles, LSU streams 5 returns
    k = 0;
    mem_valid = 1; mem_rd = 4'(8); mem_data = 16'hC000;
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1; alu_rd = 1; alu_data = 16'hA000 + 16'(c);
      acc = mem_valid && mem_ready;
      tick();
      if (acc) begin
        k++;
        mem_rd = 4'(8 + k); mem_data = 16'hC000 + 16'(k);
      end
      chk("cont_alu_d", 32'(D), 32'hA000 + 32'(c));
      chk("cont_count", 32'(fifo_count), (c < 4) ? 32'(c + 1) : 32'd4);
    end
    chk("cont_full_ready", 32'(mem_ready), 0);
    alu_valid = 0;
    chk("cont_no_popthru", 32'(mem_ready), 0);
    for (int d = 0; d < 5; d++) begin
      acc = mem_valid && mem_ready;
      tick();
      if (acc) begin
        k++;
        if (k == 5) mem_valid = 0;
      end
      chk("drain_regwe", 32'(RegWE), 1);
      chk("drain_nd", 32'(nD), 32'(8 + d));
      chk("drain_d", 32'(D), 32'hC000 + 32'(d));
    end
    chk("drain_valid_off", 32'(mem_valid), 0);
    tick();
    chk("drain_idle", 32'(RegWE), 0);
    chk("drain_empty", 32'(fifo_count), 0);

    // R0 suppression
    alu_valid = 1; alu_rd = 0; alu_data = 16'hFFFF; ld_issue = 1; ld_issue_rd = 0;
    tick();
    alu_valid = 0; ld_issue = 0;
    chk("r0_alu_regwe", 32'(RegWE), 0);
    chk("r0_alu_nd", 32'(nD), 0);
    chk("r0_pend", 32'(pending), 0);
    mem_valid = 1; mem_rd = 0; mem_data = 16'h5555;
    tick();
    mem_valid = 0;
    chk("r0_push", 32'(fifo_count), 1);
    tick();
    chk("r0_pop", 32'(fifo_count), 0);
    chk("r0_ld_regwe", 32'(RegWE), 0);
    tick();
    chk("r0_regwe_after", 32'(RegWE), 0);
    chk("r0_pend_after", 32'(pending), 0);

    // Same-edge set/clear on r7
    ld_issue = 1; ld_issue_rd = 7;
    tick();
    ld_issue = 0;
    chk("se_pend_set", 32'(pending), 32'h0080);
    mem_valid = 1; mem_rd = 7; mem_data = 16'h7777;
    tick();
    mem_valid = 0;
    tick();
    chk("se_regwe", 32'(RegWE), 1);
    chk("se_nd", 32'(nD), 7);
    ld_issue = 1; ld_issue_rd = 7;
    tick();
    ld_issue = 0;
    chk("se_set_wins", 32'(pending), 32'h0080);
    tick();
    chk("se_set_holds", 32'(pending), 32'h0080);

    // Reset mid-stream with 3 entries buffered
    alu_valid = 1; alu_rd = 2; alu_data = 16'h0202;
    ld_issue = 1; ld_issue_rd = 9;
    mem_valid = 1; mem_rd = 10; mem_data = 16'hAAAA;
    tick();
    ld_issue = 0;
    tick();
    tick();
    mem_valid = 0;
    chk("mid_count3", 32'(fifo_count), 3);
    chk("mid_pend", 32'(pending), 32'h0280);
    Reset = 1'b1;
    tick();
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_pend", 32'(pending), 0);
    chk("mid_rst_regwe", 32'(RegWE), 0);
    chk("mid_rst_ready", 32'(mem_ready), 1);
    alu_valid = 0;
    Reset = 1'b0;
    tick();
    chk("mid_post_regwe", 32'(RegWE), 0);
    chk("mid_post_count", 32'(fifo_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
